// File: rtl/smg_scan_ctrl_if.sv
// rtl/smg_scan_ctrl_if.sv - load/display bundle between a value source and the 7-seg scan controller
interface smg_scan_ctrl_if #(
    parameter int DIGITS = 6
) ();
    logic [4*DIGITS-1:0] bcd_i;
    logic                load_i;
    logic [3:0]          dat_o;
    logic [DIGITS-1:0]   sel_o;
    logic                frame_o;

    // Value source side: presents BCD and load strobe, observes the scan outputs.
    modport master (
        output bcd_i, load_i,
        input  dat_o, sel_o, frame_o
    );

    // Scan controller side.
    modport slave (
        input  bcd_i, load_i,
        output dat_o, sel_o, frame_o
    );
endinterface

// File: rtl/smg_scan_ctrl.sv
// rtl/smg_scan_ctrl.sv - multiplexed common-anode 7-seg scan controller with blanking gap and leading-zero suppression
module smg_scan_ctrl #(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int LZB_EN    = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    smg_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    // cnt/idx/state describe the slot position whose outputs are produced at the next edge.
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] pending;
    logic                pend_v;

    logic                frame_start;
    logic [4*DIGITS-1:0] active_nxt;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   show_sel;
    logic [3:0]          cur_nib;
    logic [3:0]          nib;
    logic                zrun;

    // Frame transfer, blanking mask (top-down leading-zero run) and digit selection.
    always_comb begin
        frame_start = (idx == '0) && (cnt == '0);
        active_nxt  = (frame_start && pend_v) ? pending : active;
        blank       = '0;
        show_sel    = '1;
        cur_nib     = '0;
        nib         = '0;
        zrun        = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib      = active[4*k +: 4];
            zrun     = zrun & (nib == 4'd0);
            blank[k] = (nib > 4'd9) | ((LZB_EN != 0) && (k != 0) && zrun);
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib     = active_nxt[4*k +: 4];
                show_sel[k] = blank[k];
            end
        end
    end

    // Slot FSM, value latching and registered display outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            pend_v      <= 1'b0;
            bus.dat_o   <= 4'd0;
            bus.sel_o   <= '1;
            bus.frame_o <= 1'b0;
        end else begin
            active      <= active_nxt;
            bus.frame_o <= frame_start;
            if (frame_start) begin
                pend_v <= 1'b0;
            end
            // A load on the transfer edge wins over the clear and waits a frame.
            if (bus.load_i) begin
                pending <= bus.bcd_i;
                pend_v  <= 1'b1;
            end

            case (state)
                BLANK: begin
                    bus.sel_o <= '1;
                    bus.dat_o <= cur_nib;
                end
                SHOW: begin
                    bus.sel_o <= show_sel;
                end
                default: begin
                    bus.sel_o <= '1;
                end
            endcase

            if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                cnt   <= '0;
                state <= BLANK;
                idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state <= SHOW;
                end
            end
        end
    end
endmodule
